// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - 7-bit I2C target exposing 8 writable and 8 read-only byte registers
// Optional I2C_TARGET_AUTOINC_EN: advance the register pointer after every data byte.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'b010_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [63:0] status_i,
    output logic [63:0] regs_o,
    output logic        wr_val_o,
    output logic [3:0]  wr_addr_o,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [3:0] ptr_q;
    logic [3:0] ptr_adv;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic       last_bit;

    assign sda_o = 1'b0;

    // Bus idles high, so the synchronizers reset to 1 to avoid a false START/STOP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    assign rx_byte  = {shift_q[6:0], sda_s};
    assign last_bit = (bit_cnt_q == 4'd7);
    assign rd_byte  = ptr_q[3] ? status_i[{ptr_q[2:0], 3'b000} +: 8]
                               : regs_o[{ptr_q[2:0], 3'b000} +: 8];

`ifdef I2C_TARGET_AUTOINC_EN
    assign ptr_adv = ptr_q + 4'd1;
`else
    assign ptr_adv = ptr_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            ptr_q     <= 4'd0;
            regs_o    <= 64'd0;
            wr_val_o  <= 1'b0;
            wr_addr_o <= 4'd0;
            sda_t     <= 1'b1;
        end else begin
            wr_val_o <= 1'b0;
            if (start_det) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= 4'd0;
                sda_t     <= 1'b1;
            end else if (stop_det) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= 4'd0;
                sda_t     <= 1'b1;
            end else if (scl_rise) begin
                case (state_q)
                    ST_ADDR: begin
                        shift_q   <= rx_byte;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (last_bit)
                            state_q <= (rx_byte[7:1] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                    ST_PTR: begin
                        shift_q   <= rx_byte;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            ptr_q   <= rx_byte[3:0];
                            state_q <= ST_PTR_ACK;
                        end
                    end
                    ST_WDATA: begin
                        shift_q   <= rx_byte;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            if (!ptr_q[3]) begin
                                regs_o[{ptr_q[2:0], 3'b000} +: 8] <= rx_byte;
                                wr_val_o  <= 1'b1;
                                wr_addr_o <= ptr_q;
                            end
                            ptr_q   <= ptr_adv;
                            state_q <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: bit_cnt_q <= bit_cnt_q + 4'd1;
                    ST_RDATA_ACK: begin
                        if (sda_s)
                            state_q <= ST_IGNORE;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    // First fall in an ACK state starts the ACK, the second ends it.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (sda_t) begin
                            sda_t <= 1'b0;
                        end else begin
                            bit_cnt_q <= 4'd0;
                            if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                                shift_q <= rd_byte;
                                sda_t   <= rd_byte[7];
                                ptr_q   <= ptr_adv;
                                state_q <= ST_RDATA;
                            end else begin
                                sda_t   <= 1'b1;
                                state_q <= (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_t     <= 1'b1;
                            bit_cnt_q <= 4'd0;
                            state_q   <= ST_RDATA_ACK;
                        end else begin
                            sda_t   <= shift_q[6];
                            shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end
                    ST_RDATA_ACK: begin
                        shift_q   <= rd_byte;
                        sda_t     <= rd_byte[7];
                        ptr_q     <= ptr_adv;
                        bit_cnt_q <= 4'd0;
                        state_q   <= ST_RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

Responder-side I2C block: a 7-bit-addressed target exposing a 16-byte register file to an external I2C controller. Registers 0x0–0x7 are writable over the bus and drive fabric outputs. Registers 0x8–0xF are read-only and mirror fabric status inputs. It serves as the bus model for the panel controller, and as a debug port letting an external host read and write TOY front-panel state.

## Interface
- `ADDR`, default 7'b010_0000: target device address.
- `clk_i` in 1: system clock; must be ≥ 20× SCL frequency.
- `rst_ni` in 1: asynchronous, active-low reset.
- `status_i` in 64: read-only bytes; byte k = `status_i[8k+7:8k]` appears at register 0x8+k.
- `regs_o` out 64: writable registers; byte k = register k.
- `wr_val_o` out 1: one-cycle pulse when a bus write commits.
- `wr_addr_o` out 4: register index of the committed write; valid with `wr_val_o`.
- `scl_i` in 1: SCL pin input; the block never stretches the clock.
- `sda_i` in 1: SDA pin input.
- `sda_o` out 1: tied to 0.
- `sda_t` out 1: 1 releases SDA (high-Z), 0 pulls SDA low.

## Operation
- **Input conditioning:** `scl_i` and `sda_i` pass through 2-flop synchronizers, then a previous-value register for edge detect.
- **Bus conditions:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bits are sampled on SCL rising edges.
  - The block changes SDA only on SCL falling edges.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **Global transitions:**
  - START in any state → ADDR, bit counter cleared, SDA released.
  - STOP in any state → IDLE, SDA released.
- **ADDR:** shift 8 bits, MSB first.
  - Upper 7 bits == `ADDR` → ADDR_ACK.
  - Otherwise → IGNORE, which holds until START or STOP.
- **ADDR_ACK:**
  - Pull SDA low from the SCL fall after bit 8 until the SCL fall after bit 9.
  - R/W = 0 → PTR.
  - R/W = 1 → load the shift register from `reg[ptr]` on that SCL fall → RDATA.
- **PTR:** receive 8 bits; `ptr <= byte[3:0]`, upper nibble discarded; ACK → PTR_ACK → WDATA.
- **WDATA:** receive 8 bits; commit on the 8th SCL rising edge.
  - ptr < 8: `regs_o` byte updated and `wr_val_o` pulsed with `wr_addr_o = ptr`.
  - ptr ≥ 8: data discarded and no pulse, but the byte is still ACKed.
  - Then WDATA_ACK → WDATA.
- **RDATA:** drive the MSB first.
  - SDA is released for a 1 bit and pulled low for a 0 bit.
  - After 8 bits, release SDA → RDATA_ACK.
- **RDATA_ACK:** sample the controller's bit on SCL rising.
  - ACK (0): reload `reg[ptr]` on the next SCL fall → RDATA.
  - NACK (1): → IGNORE.
- **Register source:** `reg[ptr]` is `regs_o` byte for ptr < 8, otherwise the `status_i` byte sampled at load time.
- **Pointer arithmetic:** 4-bit with wrap-around; 0xF + 1 = 0x0.
- A read without a preceding pointer write uses the pointer left by the last transaction; the pointer resets to 0.

## Timing
- **Reset values:**
  - `regs_o` = 0, `wr_val_o` = 0, `wr_addr_o` = 0, `sda_t` = 1, `sda_o` = 0.
  - ptr = 0, state IDLE.
  - Reset asserted mid-transfer releases SDA asynchronously.
- **Detection latency:** a pin edge is detected 3 clk_i cycles after it reaches the pin (2 sync flops + edge register).
- **SDA output latency:** `sda_t` changes on the clk_i cycle after the SCL falling edge is detected, so it lands well inside the SCL low phase.
- **Write commit:** `wr_val_o` is high for exactly 1 clk_i cycle, in the cycle after the 8th-bit SCL rise is detected. `regs_o` shows the new value in that same cycle.
- **Simultaneous events:** START/STOP detection takes priority over a simultaneous SCL edge.
- **Partial bytes:** a START or STOP arriving mid-byte discards the partial byte with no commit.

## Configuration
- `I2C_TARGET_AUTOINC_EN`:
  - Defined: ptr increments with wrap after every data byte (write commit or read load). Multi-byte bursts therefore sweep consecutive registers.
  - Undefined: ptr changes only in PTR, so every burst byte targets the same register.

## Test plan
- **Write burst:** START, 0x40, ptr 0x02, data 0xA5, 0x3C, STOP →
  - ACK on all 4 bytes.
  - `wr_val_o` pulses with `wr_addr_o` = 2 then 3; regs 2/3 = 0xA5/0x3C.
  - With the macro undefined: a single register 2 = 0x3C, two pulses both with `wr_addr_o` = 2.
- **Combined read:** `status_i` byte 0 = 0x5A; START, 0x40, ptr 0x08, repeated START, 0x41, read 2 bytes (ACK then NACK), STOP →
  - Bytes read are 0x5A, then `status_i` byte 1.
  - SDA released after the NACK.
- **Address mismatch:** START, 0x42, 0x00, 0xFF, STOP →
  - SDA never pulled low.
  - No `wr_val_o`; `regs_o` unchanged.
- **Wrap and read-only writes:** ptr 0x0F, write 0x11, 0x22 →
  - 0x11 ACKed and discarded (no pulse).
  - reg 0 = 0x22 with `wr_val_o` and `wr_addr_o` = 0.
- **Aborted transfers:**
  - STOP after 4 bits of a data byte → no commit, state IDLE.
  - `rst_ni` low during ADDR_ACK → `sda_t` = 1 immediately, `regs_o` = 0.
